// File: rtl/game_pkg.sv
// Shared boxing-game definitions: enemy FSM state encodings, screen limits
// and the lane-to-x mapping used by the enemy controller.
package game_pkg;

    // Enemy FSM state encodings, also exported on state_out
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MOVE    = 3'd1,
        ST_WINDUP  = 3'd2,
        ST_PUNCH   = 3'd3,
        ST_RECOVER = 3'd4,
        ST_STUN    = 3'd5
    } enemy_state_e;

    // Visible screen limits of the VGA drawer
    localparam int unsigned X_MAX = 159;
    localparam int unsigned Y_MAX = 119;

    // x coordinate of a lane given the first-lane x and the lane pitch
    function automatic logic [7:0] lane_x(input int unsigned lane,
                                          input int unsigned x0,
                                          input int unsigned pitch);
        return 8'(x0 + lane * pitch);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Rate divider: strobes tick for one clock whenever the down-counter is 0,
// then reloads period. clr holds the counter at 0 and suppresses the strobe,
// so the first clock after clr drops produces a tick.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   clr            : synchronous clear (game not running)
//   period         : reload value, tick period minus 1
//   tick           : 1-clock strobe
module tick_gen #(
    parameter int unsigned DIV_W = 28
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = !clr && (cnt == '0);

    // Down-counter with reload on terminal count
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt == '0) begin
            cnt <= period;
        end else begin
            cnt <= cnt - DIV_W'(1);
        end
    end

endmodule

// File: rtl/enemy_behaviour_ctrl.sv
// Enemy controller for the boxing game: steps the opponent between lanes at a
// speed-dependent rate and periodically runs a telegraphed attack
// (WINDUP -> PUNCH -> RECOVER). A player hit during WINDUP or RECOVER stuns it.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   enable         : game running; low returns the FSM to IDLE
//   speed          : step every (4 - speed) ticks
//   aggression     : attack after 8 - 2*aggression steps
//   rand_val       : LFSR value used for the lane choice
//   hit_in         : 1-clock pulse, player landed a punch
//   x_out, y_out   : enemy position for the drawer
//   move           : 1-clock pulse per lane step (LFSR advance enable)
//   windup, punch, stunned : phase flags decoded from the state
//   state_out      : current FSM state encoding
module enemy_behaviour_ctrl
    import game_pkg::*;
#(
    parameter int unsigned DIV_W         = 28,
    parameter int unsigned BASE_DIV      = 12_499_999,
    parameter int unsigned N_LANES       = 3,
    parameter int unsigned LANE_X0       = 20,
    parameter int unsigned LANE_PITCH    = 40,
    parameter int unsigned Y_POS         = 8,
    parameter int unsigned WINDUP_TICKS  = 2,
    parameter int unsigned PUNCH_TICKS   = 1,
    parameter int unsigned RECOVER_TICKS = 2,
    parameter int unsigned STUN_TICKS    = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [1:0] speed,
    input  logic [1:0] aggression,
    input  logic [7:0] rand_val,
    input  logic       hit_in,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic       move,
    output logic       windup,
    output logic       punch,
    output logic       stunned,
    output logic [2:0] state_out
);

    localparam int unsigned LANE_W = (N_LANES > 2) ? $clog2(N_LANES) : 1;
    localparam int unsigned CNT_W  = 4;
    localparam logic [LANE_W-1:0] RESET_LANE = LANE_W'(N_LANES / 2);
    localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(N_LANES - 1);

    // Elaboration-time parameter sanity
    if (LANE_X0 + (N_LANES - 1) * LANE_PITCH > X_MAX) begin : g_x_range_err
        $error("enemy_behaviour_ctrl: rightmost lane x=%0d exceeds X_MAX=%0d",
               LANE_X0 + (N_LANES - 1) * LANE_PITCH, X_MAX);
    end
    if (N_LANES < 2 || N_LANES > 8) begin : g_lanes_err
        $error("enemy_behaviour_ctrl: N_LANES=%0d outside 2..8", N_LANES);
    end
    if (Y_POS > Y_MAX) begin : g_y_range_err
        $error("enemy_behaviour_ctrl: Y_POS=%0d exceeds Y_MAX=%0d", Y_POS, Y_MAX);
    end

    enemy_state_e      state, state_nxt;
    logic [LANE_W-1:0] lane, lane_nxt, rand_lane, step_lane;
    logic [CNT_W-1:0]  phase_cnt, phase_nxt, phase_inc, phase_limit;
    logic [CNT_W-1:0]  move_cnt, move_cnt_nxt, move_cnt_inc;
    logic [CNT_W-1:0]  step_div, step_div_nxt, speed_div, attack_thr;
    logic              tick, tick_clr, phase_done, step;

    assign tick_clr = !enable;

    tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (tick_clr),
        .period  (DIV_W'(BASE_DIV)),
        .tick    (tick)
    );

    assign y_out     = 7'(Y_POS);
    assign state_out = state;

    // Lane choice: random lane, bumped to the next lane (wrapping) on a repeat
    assign rand_lane = LANE_W'(rand_val % 8'(N_LANES));
    assign step_lane = (rand_lane != lane)  ? rand_lane :
                       (lane == LAST_LANE)  ? '0        : lane + LANE_W'(1);

    assign speed_div    = CNT_W'(4) - {2'b00, speed};
    assign attack_thr   = CNT_W'(8) - {1'b0, aggression, 1'b0};
    assign phase_inc    = phase_cnt + CNT_W'(1);
    assign move_cnt_inc = move_cnt + CNT_W'(1);

    // Number of ticks the current state lasts (MOVE: ticks per step)
    always_comb begin
        phase_limit = step_div;
        case (state)
            ST_WINDUP:  phase_limit = CNT_W'(WINDUP_TICKS);
            ST_PUNCH:   phase_limit = CNT_W'(PUNCH_TICKS);
            ST_RECOVER: phase_limit = CNT_W'(RECOVER_TICKS);
            ST_STUN:    phase_limit = CNT_W'(STUN_TICKS);
            default:    phase_limit = step_div;
        endcase
    end

    assign phase_done = tick && (phase_inc >= phase_limit);

    // Next-state, counter and lane logic
    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase_cnt;
        move_cnt_nxt = move_cnt;
        lane_nxt     = lane;
        step_div_nxt = step_div;
        step         = 1'b0;

        if (!enable) begin
            state_nxt    = ST_IDLE;
            phase_nxt    = '0;
            move_cnt_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt    = ST_MOVE;
                    phase_nxt    = '0;
                    step_div_nxt = speed_div;
                end
                ST_MOVE: begin
                    if (phase_done) begin
                        step         = 1'b1;
                        phase_nxt    = '0;
                        lane_nxt     = step_lane;
                        step_div_nxt = speed_div;
                        if (move_cnt_inc >= attack_thr) begin
                            move_cnt_nxt = '0;
                            state_nxt    = ST_WINDUP;
                        end else begin
                            move_cnt_nxt = move_cnt_inc;
                        end
                    end else if (tick) begin
                        phase_nxt = phase_inc;
                    end
                end
                ST_WINDUP: begin
                    // hit wins over a coincident tick
                    if (hit_in) begin
                        state_nxt    = ST_STUN;
                        phase_nxt    = '0;
                        move_cnt_nxt = '0;
                    end else if (phase_done) begin
                        state_nxt = ST_PUNCH;
                        phase_nxt = '0;
                    end else if (tick) begin
                        phase_nxt = phase_inc;
                    end
                end
                ST_PUNCH: begin
                    if (phase_done) begin
                        state_nxt = ST_RECOVER;
                        phase_nxt = '0;
                    end else if (tick) begin
                        phase_nxt = phase_inc;
                    end
                end
                ST_RECOVER: begin
                    if (hit_in) begin
                        state_nxt    = ST_STUN;
                        phase_nxt    = '0;
                        move_cnt_nxt = '0;
                    end else if (phase_done) begin
                        state_nxt    = ST_MOVE;
                        phase_nxt    = '0;
                        step_div_nxt = speed_div;
                    end else if (tick) begin
                        phase_nxt = phase_inc;
                    end
                end
                ST_STUN: begin
                    if (phase_done) begin
                        state_nxt    = ST_MOVE;
                        phase_nxt    = '0;
                        step_div_nxt = speed_div;
                    end else if (tick) begin
                        phase_nxt = phase_inc;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    phase_nxt = '0;
                end
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
            move_cnt  <= '0;
            step_div  <= CNT_W'(4);
            lane      <= RESET_LANE;
            x_out     <= lane_x(N_LANES / 2, LANE_X0, LANE_PITCH);
            move      <= 1'b0;
            windup    <= 1'b0;
            punch     <= 1'b0;
            stunned   <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase_cnt <= phase_nxt;
            move_cnt  <= move_cnt_nxt;
            step_div  <= step_div_nxt;
            lane      <= lane_nxt;
            // x follows lane one clock later
            x_out     <= lane_x(32'(lane), LANE_X0, LANE_PITCH);
            move      <= step;
            windup    <= (state_nxt == ST_WINDUP);
            punch     <= (state_nxt == ST_PUNCH);
            stunned   <= (state_nxt == ST_STUN);
        end
    end

endmodule
